// File: rtl/weight_mem_1x1_stream.sv
// -----------------------------------------------------------------------------
// weight_mem_1x1_stream
// Weight store for the 1x1 EX/PR convolution datapath. The loader streams one
// bank segment (ROW_LEN words) per beat; NUM_BANKS beats are packed into one
// wide line and committed at an auto-incrementing line address. Burst reads
// return consecutive lines to the PE array with a fixed 1-cycle latency.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-low reset
//   wr_start/wr_base   open a load session at line wr_base
//   wr_valid/wr_ready  beat handshake; wr_data is one bank segment
//   wr_last            ends the session on a bank-(NUM_BANKS-1) beat
//   rd_start/rd_base   start a burst of rd_len lines (0 means 1)
//   rd_valid/data_out  returned line, held while rd_valid is low
//   rd_done            pulse with the final beat of a burst
//   wr_busy/rd_busy    session / burst in progress
//   err                sticky out-of-range access flag
// -----------------------------------------------------------------------------
module weight_mem_1x1_stream #(
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned ROW_LEN    = 16,
    parameter int unsigned NUM_BANKS  = 16,
    parameter int unsigned DEPTH      = 657,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_start,
    input  logic [ADDR_W-1:0]                      wr_base,
    input  logic                                   wr_valid,
    output logic                                   wr_ready,
    input  logic [ROW_LEN*DATA_WIDTH-1:0]          wr_data,
    input  logic                                   wr_last,
    input  logic                                   rd_start,
    input  logic [ADDR_W-1:0]                      rd_base,
    input  logic [ADDR_W-1:0]                      rd_len,
    output logic                                   rd_valid,
    output logic [NUM_BANKS*ROW_LEN*DATA_WIDTH-1:0] data_out,
    output logic                                   rd_done,
    output logic                                   wr_busy,
    output logic                                   rd_busy,
    output logic                                   err
);

    localparam int unsigned SEG_W  = ROW_LEN * DATA_WIDTH;
    localparam int unsigned LINE_W = NUM_BANKS * SEG_W;
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    typedef enum logic {W_IDLE, W_LOAD}  wstate_t;
    typedef enum logic {R_IDLE, R_BURST} rstate_t;

    logic [LINE_W-1:0] r_mem [DEPTH];

    wstate_t           r_wstate;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [BANK_W-1:0] r_bank_cnt;
    logic [LINE_W-1:0] r_line;
    logic              r_wr_busy;

    rstate_t           r_rstate;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic              r_rd_valid;
    logic              r_rd_done;
    logic              r_rd_busy;
    logic [LINE_W-1:0] r_data_out;
    logic              r_err;

    logic              w_wr_accept;
    logic              w_wr_commit;
    logic              w_wr_in_range;
    logic              w_mem_we;
    logic              w_rd_issue;
    logic              w_rd_in_range;
    logic              w_rd_re;
    logic [LINE_W-1:0] w_line;

    assign w_wr_accept   = (r_wstate == W_LOAD) && wr_valid;
    assign w_wr_commit   = w_wr_accept && (r_bank_cnt == LAST_BANK);
    assign w_wr_in_range = (32'(r_wr_addr) < DEPTH);
    // rst gate keeps a commit coincident with reset from reaching memory
    assign w_mem_we      = w_wr_commit && w_wr_in_range && rst;
    assign w_rd_issue    = (r_rstate == R_BURST);
    assign w_rd_in_range = (32'(r_rd_addr) < DEPTH);
    assign w_rd_re       = w_rd_issue && w_rd_in_range;

    // Assembly line with the incoming beat merged, so a commit includes it
    always_comb begin
        w_line = r_line;
        w_line[32'(r_bank_cnt) * SEG_W +: SEG_W] = wr_data;
    end

    // Line assembly register (contents irrelevant until a full line is built)
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_line <= w_line;
        end
    end

    // Write FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wstate   <= W_IDLE;
            r_wr_addr  <= '0;
            r_bank_cnt <= '0;
            r_wr_busy  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (wr_start) begin
                        r_wstate   <= W_LOAD;
                        r_wr_addr  <= wr_base;
                        r_bank_cnt <= '0;
                        r_wr_busy  <= 1'b1;
                    end
                end
                W_LOAD: begin
                    if (wr_valid) begin
                        if (r_bank_cnt == LAST_BANK) begin
                            r_bank_cnt <= '0;
                            r_wr_addr  <= r_wr_addr + ADDR_W'(1);
                            if (!w_wr_in_range || wr_last) begin
                                r_wstate  <= W_IDLE;
                                r_wr_busy <= 1'b0;
                            end
                        end else begin
                            r_bank_cnt <= r_bank_cnt + BANK_W'(1);
                        end
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_wr_busy <= 1'b0;
                end
            endcase
        end
    end

    // Storage write port
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_addr] <= w_line;
        end
    end

    // Storage read port; nonblocking update makes same-address access read-first
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data_out <= '0;
        end else if (w_rd_re) begin
            r_data_out <= r_mem[r_rd_addr];
        end
    end

    // Read FSM: one line issued per cycle, result visible after the same edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rstate    <= R_IDLE;
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_done   <= 1'b0;
            r_rd_busy   <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_done  <= 1'b0;
            case (r_rstate)
                R_IDLE: begin
                    if (rd_start) begin
                        r_rstate    <= R_BURST;
                        r_rd_addr   <= rd_base;
                        r_remaining <= (rd_len == '0) ? ADDR_W'(1) : rd_len;
                        r_rd_busy   <= 1'b1;
                    end
                end
                R_BURST: begin
                    r_rd_addr   <= r_rd_addr + ADDR_W'(1);
                    r_remaining <= r_remaining - ADDR_W'(1);
                    if (w_rd_in_range) begin
                        r_rd_valid <= 1'b1;
                        if (r_remaining == ADDR_W'(1)) begin
                            r_rd_done <= 1'b1;
                            r_rstate  <= R_IDLE;
                            r_rd_busy <= 1'b0;
                        end
                    end else begin
                        // out-of-range line: no data, burst ends here
                        r_rd_done <= 1'b1;
                        r_rstate  <= R_IDLE;
                        r_rd_busy <= 1'b0;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_rd_busy <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error from either direction
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if ((w_wr_commit && !w_wr_in_range) || (w_rd_issue && !w_rd_in_range)) begin
            r_err <= 1'b1;
        end
    end

    assign wr_ready = r_wr_busy;
    assign wr_busy  = r_wr_busy;
    assign rd_busy  = r_rd_busy;
    assign rd_valid = r_rd_valid;
    assign rd_done  = r_rd_done;
    assign data_out = r_data_out;
    assign err      = r_err;

endmodule

// File: tb/tb_weight_mem_1x1_stream.sv
// -----------------------------------------------------------------------------
// tb_weight_mem_1x1_stream
// Directed bench for weight_mem_1x1_stream. A line-level model (array of lines
// plus a queue of expected per-cycle read results) predicts the read port; one
// compare thread checks rd_valid, rd_done and data_out on every falling edge.
// -----------------------------------------------------------------------------
module tb_weight_mem_1x1_stream;

    localparam int DW     = 14;
    localparam int RL     = 16;
    localparam int NB     = 16;
    localparam int DEPTH  = 657;
    localparam int ADDR_W = 10;
    localparam int SEG_W  = RL * DW;
    localparam int LINE_W = NB * SEG_W;

    logic              clk;
    logic              rst;
    logic              wr_start;
    logic [ADDR_W-1:0] wr_base;
    logic              wr_valid;
    logic              wr_ready;
    logic [SEG_W-1:0]  wr_data;
    logic              wr_last;
    logic              rd_start;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] rd_len;
    logic              rd_valid;
    logic [LINE_W-1:0] data_out;
    logic              rd_done;
    logic              wr_busy;
    logic              rd_busy;
    logic              err;

    weight_mem_1x1_stream dut (
        .clk      (clk),
        .rst      (rst),
        .wr_start (wr_start),
        .wr_base  (wr_base),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_last  (wr_last),
        .rd_start (rd_start),
        .rd_base  (rd_base),
        .rd_len   (rd_len),
        .rd_valid (rd_valid),
        .data_out (data_out),
        .rd_done  (rd_done),
        .wr_busy  (wr_busy),
        .rd_busy  (rd_busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic              v;
        logic              d;
        logic [LINE_W-1:0] data;
    } exp_t;

    logic [LINE_W-1:0] model_mem [DEPTH];
    exp_t              exp_q [$];
    logic [LINE_W-1:0] hold;
    logic              exp_err;
    int                n_cmp;
    int                n_fail;

    function automatic logic [LINE_W-1:0] mk_line(input int tag, input int l);
        logic [LINE_W-1:0] v;
        v = '0;
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < RL; i++)
                v[(b*RL+i)*DW +: DW] = DW'(tag*4096 + l*256 + b*16 + i);
        return v;
    endfunction

    function automatic logic [DW-1:0] get_word(input logic [LINE_W-1:0] ln, input int idx);
        return ln[idx*DW +: DW];
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk32(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_line(input string name, input logic [LINE_W-1:0] act,
                                     input logic [LINE_W-1:0] exp);
        int k;
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            k = 0;
            while (k < NB*RL - 1 && get_word(act, k) === get_word(exp, k)) k++;
            $display("FAIL %s: word %0d got %0h expected %0h at %0t",
                     name, k, get_word(act, k), get_word(exp, k), $time);
        end
    endfunction

    // Per-cycle read-port checker
    task automatic cmp_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = '0;
            chk1("rd_valid", rd_valid, e.v);
            chk1("rd_done", rd_done, e.d);
            if (e.v) hold = e.data;
            chk_line("data_out", data_out, hold);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        hold    = '0;
        exp_err = 1'b0;
        exp_q.delete();
        rst = 1'b1;
    endtask

    // Load session of nl lines; model commits each line the bench knows was written
    task automatic load(input int base, input int nl, input int tag, input bit stall);
        logic [LINE_W-1:0] ln;
        bit acc;
        bit stop;
        int guard;
        stop = 1'b0;
        wr_start = 1'b1;
        wr_base  = ADDR_W'(base);
        @(posedge clk); #1;
        wr_start = 1'b0;
        for (int l = 0; l < nl && !stop; l++) begin
            ln = mk_line(tag, l);
            for (int b = 0; b < NB && !stop; b++) begin
                wr_data = ln[b*SEG_W +: SEG_W];
                wr_last = (l == nl-1) && (b == NB-1);
                guard = 0;
                do begin
                    wr_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                    acc = wr_valid && wr_ready;
                    @(posedge clk); #1;
                    guard++;
                end while (!acc && guard < 200);
                wr_valid = 1'b0;
                chk1("beat_accept", acc, 1'b1);
                if (!acc) stop = 1'b1;
            end
            if (!stop) begin
                if (base + l < DEPTH) model_mem[base + l] = ln;
                else begin
                    exp_err = 1'b1;
                    stop    = 1'b1;
                end
                chk1("wr_busy_after_line", wr_busy, !(stop || l == nl-1));
            end
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Burst request; two idle cycles precede the first returned line
    task automatic burst(input int base, input int len);
        int   n;
        exp_t e;
        rd_start = 1'b1;
        rd_base  = ADDR_W'(base);
        rd_len   = ADDR_W'(len);
        n = (len == 0) ? 1 : len;
        e = '0;
        exp_q.push_back(e);
        exp_q.push_back(e);
        for (int j = 0; j < n; j++) begin
            if (base + j < DEPTH) begin
                e.v = 1'b1; e.d = (j == n-1); e.data = model_mem[base + j];
                exp_q.push_back(e);
            end else begin
                e.v = 1'b0; e.d = 1'b1; e.data = '0;
                exp_q.push_back(e);
                exp_err = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        rd_start = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk32("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [LINE_W-1:0] ln;
        n_cmp = 0; n_fail = 0;
        hold = '0; exp_err = 1'b0;
        rst = 1'b0;
        wr_start = 1'b0; wr_base = '0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        rd_start = 1'b0; rd_base = '0; rd_len = '0;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
        fork cmp_loop(); join_none

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_wr_ready", wr_ready, 1'b0);
        chk1("rst_wr_busy", wr_busy, 1'b0);
        chk1("rst_rd_busy", rd_busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;

        // three-line load at 0, then read it back
        load(0, 3, 0, 1'b0);
        chk1("err_after_load", err, exp_err);
        chk32("model_l1_w0", int'(get_word(model_mem[1], 0)), 256);
        chk32("model_l0_b3i2", int'(get_word(model_mem[0], 3*16+2)), 50);
        chk32("model_l2_w255", int'(get_word(model_mem[2], 255)), 767);
        burst(0, 3);
        drain();
        chk1("rd_busy_after", rd_busy, 1'b0);
        chk32("dout_l2_w255", int'(get_word(data_out, 255)), 767);

        // rd_len of zero returns one line
        burst(1, 0);
        drain();
        chk32("len0_w0", int'(get_word(data_out, 0)), 256);

        // stalled load near the top of memory
        load(650, 2, 1, 1'b1);
        burst(650, 2);
        drain();

        // same-edge commit and read of line 5: old data, then new data
        load(5, 1, 2, 1'b0);
        fork
            load(5, 1, 3, 1'b0);
            begin
                repeat (15) @(posedge clk);
                #1;
                burst(5, 1);
            end
        join
        drain();
        chk32("rfirst_old_w0", int'(get_word(data_out, 0)), 8192);
        burst(5, 1);
        drain();
        chk32("rfirst_new_w0", int'(get_word(data_out, 0)), 12288);

        // write overflow: line 656 lands, 657 is suppressed
        load(655, 1, 2, 1'b0);
        load(656, 2, 3, 1'b0);
        chk1("err_wr_oob", err, exp_err);
        chk1("wr_busy_oob", wr_busy, 1'b0);

        // read overflow: 655, 656 valid then a done-only cycle
        burst(655, 4);
        drain();
        chk1("err_rd_oob", err, exp_err);
        chk1("rd_busy_oob", rd_busy, 1'b0);

        do_reset();
        chk1("err_cleared", err, 1'b0);

        // abort a session after 8 beats
        wr_start = 1'b1; wr_base = '0;
        @(posedge clk); #1;
        wr_start = 1'b0;
        ln = mk_line(3, 0);
        for (int b = 0; b < 8; b++) begin
            wr_data  = ln[b*SEG_W +: SEG_W];
            wr_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk1("wr_busy_mid", wr_busy, 1'b1);
        wr_data = ln[8*SEG_W +: SEG_W];
        do_reset();
        wr_valid = 1'b0;
        chk1("abort_wr_ready", wr_ready, 1'b0);
        chk1("abort_wr_busy", wr_busy, 1'b0);
        chk1("abort_rd_busy", rd_busy, 1'b0);
        chk1("abort_rd_valid", rd_valid, 1'b0);
        chk1("abort_rd_done", rd_done, 1'b0);
        chk1("abort_err", err, 1'b0);
        chk_line("abort_dout", data_out, '0);
        burst(0, 3);
        drain();
        chk32("abort_l0_kept", int'(get_word(hold, 0)), 512);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
